frame_wr_ctrl: RTL and testbench

FRAME_WR_CTRL -- requirements
Module: frame_wr_ctrl

---
 rtl/frame_wr_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_frame_wr_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_wr_ctrl.sv
// frame_wr_ctrl: turns a BGR byte stream (3 bytes per pixel) into 24-bit
// frame-buffer writes, using image dimensions latched from a header parser.
//
// Optional feature macro: FRAME_ROW_PAD_EN
//   defined   -> each row is followed by width[1:0] pad bytes that are accepted
//                and discarded (rows padded to a multiple of 4 bytes)
//   undefined -> rows are contiguous; the PAD state is never entered
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle pulse arming the controller for a new frame
//   hdr_valid   header dimensions valid
//   width       image width in pixels
//   height      image height in pixels
//   byte_valid  stream byte available
//   byte_data   stream byte (B, G, R order)
//   byte_ready  byte accepted this cycle when byte_valid is also high
//   pix_we      one-cycle frame-buffer write strobe
//   pix_addr    frame-buffer write address
//   pix_data    assembled pixel {R,G,B}
//   busy        controller not idle
//   frame_done  one-cycle pulse after the frame completes
//   err         error flag, held until the next start
module frame_wr_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hdr_valid,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [23:0]       pix_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitHdr,
        StPixel,
        StPad,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       w_q, w_d;
    logic [15:0]       h_q, h_d;
    logic [15:0]       col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        pad_q, pad_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        b_q, b_d;
    logic [7:0]        g_q, g_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [23:0]       pdata_q, pdata_d;
    logic              done_q, done_d;

    logic [1:0] pad_len;
    logic       xfer;
    logic       last_col;
    logic       last_row;
    logic       addr_full;

`ifdef FRAME_ROW_PAD_EN
    assign pad_len = w_q[1:0];
`else
    assign pad_len = 2'd0;
`endif

    assign byte_ready = (state_q == StPixel) || (state_q == StPad);
    assign busy       = (state_q != StIdle);
    assign err        = (state_q == StErr);
    assign pix_we     = we_q;
    assign pix_addr   = paddr_q;
    assign pix_data   = pdata_q;
    assign frame_done = done_q;

    assign xfer      = byte_valid && byte_ready;
    assign last_col  = (col_q == w_q - 16'd1);
    assign last_row  = (row_q == h_q - 16'd1);
    assign addr_full = &addr_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        addr_d  = addr_q;
        b_d     = b_q;
        g_d     = g_q;
        we_d    = 1'b0;
        paddr_d = paddr_q;
        pdata_d = pdata_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StWaitHdr;
            end
            StWaitHdr: begin
                if (hdr_valid) begin
                    w_d    = width;
                    h_d    = height;
                    col_d  = 16'd0;
                    row_d  = 16'd0;
                    idx_d  = 2'd0;
                    pad_d  = 2'd0;
                    addr_d = '0;
                    if (width == 16'd0 || height == 16'd0) state_d = StErr;
                    else                                    state_d = StPixel;
                end
            end
            StPixel: begin
                if (xfer) begin
                    case (idx_q)
                        2'd0: begin
                            b_d   = byte_data;
                            idx_d = 2'd1;
                        end
                        2'd1: begin
                            g_d   = byte_data;
                            idx_d = 2'd2;
                        end
                        default: begin
                            idx_d   = 2'd0;
                            pad_d   = 2'd0;
                            we_d    = 1'b1;
                            paddr_d = addr_q;
                            pdata_d = {byte_data, g_q, b_q};
                            addr_d  = addr_q + ADDR_W'(1);
                            if (last_col) begin
                                col_d = 16'd0;
                                row_d = row_q + 16'd1;
                            end else begin
                                col_d = col_q + 16'd1;
                            end
                            // Final pixel wins over address overflow: nothing remains.
                            if (last_col && last_row) begin
                                state_d = (pad_len != 2'd0) ? StPad : StDone;
                            end else if (addr_full) begin
                                state_d = StErr;
                            end else if (last_col && pad_len != 2'd0) begin
                                state_d = StPad;
                            end
                        end
                    endcase
                end
            end
            StPad: begin
                if (xfer) begin
                    if (pad_q == pad_len - 2'd1) begin
                        pad_d = 2'd0;
                        // Row counter has already advanced past the padded row.
                        state_d = (row_q == h_q) ? StDone : StPixel;
                    end else begin
                        pad_d = pad_q + 2'd1;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                if (start) state_d = StWaitHdr;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            w_q     <= 16'd0;
            h_q     <= 16'd0;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            idx_q   <= 2'd0;
            pad_q   <= 2'd0;
            addr_q  <= '0;
            b_q     <= 8'd0;
            g_q     <= 8'd0;
            we_q    <= 1'b0;
            paddr_q <= '0;
            pdata_q <= 24'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            addr_q  <= addr_d;
            b_q     <= b_d;
            g_q     <= g_d;
            we_q    <= we_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_wr_ctrl.sv
`timescale 1ns/1ps
module tb_frame_wr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, hdr_valid, byte_valid;
    logic [15:0] width, height;
    logic [7:0]  byte_data;
    logic        byte_ready, pix_we, busy, frame_done, err;
    logic [16:0] pix_addr;
    logic [23:0] pix_data;

    // Second instance with a tiny address space for the overflow case.
    logic        start_s, hdr_valid_s, byte_valid_s;
    logic        byte_ready_s, pix_we_s, busy_s, frame_done_s, err_s;
    logic [1:0]  pix_addr_s;
    logic [23:0] pix_data_s;

    frame_wr_ctrl #(.ADDR_W(17)) dut (
        .clk(clk), .reset(rst_n), .start(start), .hdr_valid(hdr_valid),
        .width(width), .height(height), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    frame_wr_ctrl #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(rst_n), .start(start_s), .hdr_valid(hdr_valid_s),
        .width(width), .height(height), .byte_valid(byte_valid_s), .byte_data(byte_data),
        .byte_ready(byte_ready_s), .pix_we(pix_we_s), .pix_addr(pix_addr_s),
        .pix_data(pix_data_s), .busy(busy_s), .frame_done(frame_done_s), .err(err_s)
    );

    typedef struct {
        bit          done;
        int unsigned addr;
        logic [23:0] data;
        int          gap;   // required cycles from last write to frame_done, 0 = any
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   last_we = 0;
    int   last_we_s = 0;
    int   pad_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic exp_wr(input bit sm, input int unsigned a, input logic [23:0] d);
        exp_t e;
        e.done = 1'b0; e.addr = a; e.data = d; e.gap = 0;
        if (sm) sq.push_back(e); else q.push_back(e);
    endtask

    task automatic exp_done(input bit sm, input int gap);
        exp_t e;
        e.done = 1'b1; e.addr = 0; e.data = 24'd0; e.gap = gap;
        if (sm) sq.push_back(e); else q.push_back(e);
    endtask

    // Monitor for the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pix_we) begin
            if (q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_write: got addr %h data %h, want no write",
                         pix_addr, pix_data);
            end else begin
                e = q.pop_front();
                check("event_kind_wr", 32'd0, 32'(e.done));
                check("wr_addr", 32'(pix_addr), 32'(e.addr));
                check("wr_data", 32'(pix_data), 32'(e.data));
                last_we = cyc;
            end
        end
        if (rst_n && frame_done) begin
            if (q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_done: got frame_done=1, want 0");
            end else begin
                e = q.pop_front();
                check("event_kind_done", 32'd1, 32'(e.done));
                if (e.gap != 0) check("done_gap", 32'(cyc - last_we), 32'(e.gap));
            end
        end
    end

    // Monitor for the small-address instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pix_we_s) begin
            if (sq.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_write_s: got addr %h data %h, want no write",
                         pix_addr_s, pix_data_s);
            end else begin
                e = sq.pop_front();
                check("event_kind_wr_s", 32'd0, 32'(e.done));
                check("wr_addr_s", 32'(pix_addr_s), 32'(e.addr));
                check("wr_data_s", 32'(pix_data_s), 32'(e.data));
                last_we_s = cyc;
            end
        end
        if (rst_n && frame_done_s) begin
            if (sq.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_done_s: got frame_done=1, want 0");
            end else begin
                e = sq.pop_front();
                check("event_kind_done_s", 32'd1, 32'(e.done));
                if (e.gap != 0) check("done_gap_s", 32'(cyc - last_we_s), 32'(e.gap));
            end
        end
    end

    task automatic pulse_start(input bit sm);
        @(posedge clk); #1;
        if (sm) start_s = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_s = 1'b0;
    endtask

    task automatic send_hdr(input bit sm, input logic [15:0] w, input logic [15:0] h);
        width = w; height = h;
        if (sm) hdr_valid_s = 1'b1; else hdr_valid = 1'b1;
        @(posedge clk); #1;
        hdr_valid = 1'b0; hdr_valid_s = 1'b0;
    endtask

    task automatic send_byte(input bit sm, input logic [7:0] b);
        int t;
        t = 0;
        byte_data = b;
        if (sm) byte_valid_s = 1'b1; else byte_valid = 1'b1;
        @(negedge clk);
        while ((sm ? byte_ready_s : byte_ready) !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if ((sm ? byte_ready_s : byte_ready) !== 1'b1) begin
            n_vec++; n_miss++;
            $display("FAIL byte_handshake: got byte_ready=0 for 50 cycles, want 1");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_valid_s = 1'b0;
    endtask

    task automatic wait_drain(input bit sm);
        int t;
        t = 0;
        while ((sm ? sq.size() : q.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if ((sm ? sq.size() : q.size()) != 0) begin
            n_vec++; n_miss++;
            $display("FAIL drain: got %0d pending events, want 0", sm ? sq.size() : q.size());
            q.delete(); sq.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FRAME_ROW_PAD_EN
        pad_en = 1;
`else
        pad_en = 0;
`endif
        rst_n = 1'b0;
        start = 1'b0; hdr_valid = 1'b0; byte_valid = 1'b0;
        start_s = 1'b0; hdr_valid_s = 1'b0; byte_valid_s = 1'b0;
        width = 16'd0; height = 16'd0; byte_data = 8'd0;
        #3;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_pix_we", 32'(pix_we), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 4x1 frame, bytes 1..12; dimension changes after latching are ignored.
        pulse_start(0);
        check("wait_hdr_busy", 32'(busy), 32'd1);
        check("wait_hdr_ready", 32'(byte_ready), 32'd0);
        exp_wr(0, 0, 24'h030201);
        exp_wr(0, 1, 24'h060504);
        exp_wr(0, 2, 24'h090807);
        exp_wr(0, 3, 24'h0C0B0A);
        exp_done(0, 1);
        send_hdr(0, 16'd4, 16'd1);
        width = 16'd9; height = 16'd7;
        check("pixel_ready", 32'(byte_ready), 32'd1);
        for (int i = 1; i <= 12; i++) send_byte(0, 8'(i));
        wait_drain(0);
        check("a_idle_busy", 32'(busy), 32'd0);

        // 2x2 frame, 16 bytes available; pad bytes dropped only with padding built in.
        pulse_start(0);
`ifdef FRAME_ROW_PAD_EN
        exp_wr(0, 0, 24'h030201);
        exp_wr(0, 1, 24'h060504);
        exp_wr(0, 2, 24'h0B0A09);
        exp_wr(0, 3, 24'h0E0D0C);
        exp_done(0, 0);
`else
        exp_wr(0, 0, 24'h030201);
        exp_wr(0, 1, 24'h060504);
        exp_wr(0, 2, 24'h090807);
        exp_wr(0, 3, 24'h0C0B0A);
        exp_done(0, 1);
`endif
        send_hdr(0, 16'd2, 16'd2);
        for (int i = 1; i <= 12 + 4 * pad_en; i++) send_byte(0, 8'(i));
        wait_drain(0);
        check("b_ready_after_done", 32'(byte_ready), 32'd0);

        // Zero width -> error; stream ignored; start recovers.
        pulse_start(0);
        send_hdr(0, 16'd0, 16'd5);
        check("c_err", 32'(err), 32'd1);
        check("c_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b1; byte_data = 8'hAA;
        repeat (5) @(posedge clk);
        #1 byte_valid = 1'b0;
        check("c_err_sticky", 32'(err), 32'd1);
        pulse_start(0);
        check("c_err_cleared", 32'(err), 32'd0);
        check("c_wait_hdr_busy", 32'(busy), 32'd1);
        check("c_wait_hdr_ready", 32'(byte_ready), 32'd0);
        exp_wr(0, 0, 24'h332211);
        exp_done(0, pad_en ? 0 : 1);
        send_hdr(0, 16'd1, 16'd1);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        for (int i = 0; i < pad_en; i++) send_byte(0, 8'hEE);
        wait_drain(0);

        // 3x1 frame with byte_valid toggling every cycle.
        pulse_start(0);
        exp_wr(0, 0, 24'h030201);
        exp_wr(0, 1, 24'h060504);
        exp_wr(0, 2, 24'h090807);
        exp_done(0, pad_en ? 0 : 1);
        send_hdr(0, 16'd3, 16'd1);
        for (int i = 1; i <= 9; i++) begin
            send_byte(0, 8'(i));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3 * pad_en; i++) send_byte(0, 8'hEE);
        wait_drain(0);

        // Reset after 4 bytes of a 4-wide row: partial pixel dropped.
        pulse_start(0);
        exp_wr(0, 0, 24'h030201);
        send_hdr(0, 16'd4, 16'd1);
        for (int i = 1; i <= 4; i++) send_byte(0, 8'(i));
        rst_n = 1'b0;
        #1;
        check("e_byte_ready", 32'(byte_ready), 32'd0);
        check("e_pix_we", 32'(pix_we), 32'd0);
        check("e_pix_addr", 32'(pix_addr), 32'd0);
        check("e_pix_data", 32'(pix_data), 32'd0);
        check("e_busy", 32'(busy), 32'd0);
        check("e_frame_done", 32'(frame_done), 32'd0);
        check("e_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("e_idle_busy", 32'(busy), 32'd0);
        wait_drain(0);

        // ADDR_W=2, width 5: four writes then error, no fifth write.
        pulse_start(1);
        exp_wr(1, 0, 24'h030201);
        exp_wr(1, 1, 24'h060504);
        exp_wr(1, 2, 24'h090807);
        exp_wr(1, 3, 24'h0C0B0A);
        send_hdr(1, 16'd5, 16'd1);
        for (int i = 1; i <= 12; i++) send_byte(1, 8'(i));
        byte_valid_s = 1'b1; byte_data = 8'h0D;
        repeat (10) @(posedge clk);
        #1 byte_valid_s = 1'b0;
        check("f_err", 32'(err_s), 32'd1);
        check("f_ready", 32'(byte_ready_s), 32'd0);
        wait_drain(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
